// File: rtl/uart_pkg.sv
// Shared UART definitions: TX controller state encoding, parity modes and
// the oversample ratio used by the tick generator and the TX/RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Baud ticks per bit period; the tick generator must be built to match.
    localparam int unsigned UART_OVERSAMPLE = 16;

    // Parity bit from the XOR-reduction of the data word.
    function automatic logic parity_bit(input parity_e mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts one word over valid/ready and sends it
// as start + data (LSB first) + optional parity + stop bits, paced by an
// externally generated oversample tick.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_ctrl: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx_ctrl: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 2) begin : g_bad_oversample
        $fatal(1, "uart_tx_ctrl: OVERSAMPLE must be at least 2");
    end

    uart_tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    // A bit period closes on the last oversample tick of the period.
    assign bit_end = baud_tick && (cnt_q == CNT_LAST);

    // Next-state, counters and registered line level for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        // Tick phase is not realigned at accept; the counter only runs in a frame.
        if (state_q != TX_IDLE && baud_tick) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = parity_bit(PAR_MODE, ^tx_data);
                    idx_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PAR_MODE == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = TX_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the state being entered so tx is a clean flop output.
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shift_d[0];
            TX_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // Control state and the line register; reset idles the line immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Word and parity holding registers; only meaningful once a word is accepted.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign tx_ready = (state_q == TX_IDLE);
    assign busy     = (state_q != TX_IDLE);
    assign tx       = tx_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four frame formats side by side, each frame
// checked cycle by cycle against a bit-list model indexed by elapsed ticks.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       valid [4];
    logic [7:0] data  [4];
    logic       txo   [4];
    logic       bsy   [4];
    logic       dn    [4];
    logic       rdy   [4];

    // Tick every third clock for the OVERSAMPLE=4 instance.
    logic [1:0] ph = 2'd0;
    logic       tick3;
    always @(posedge clk) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
    assign tick3 = (ph == 2'd0);

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(1'b1), .tx_valid(valid[0]), .tx_data(data[0]),
        .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(1'b1), .tx_valid(valid[1]), .tx_data(data[1]),
        .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(1'b1), .tx_valid(valid[2]), .tx_data(data[2]),
        .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(4)) u3 (
        .clk(clk), .rst_n(rst_n), .baud_tick(tick3), .tx_valid(valid[3]), .tx_data(data[3]),
        .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .tx_done(dn[3]));

    function automatic int os_of(input int k);
        return (k == 3) ? 4 : 16;
    endfunction

    function automatic int par_of(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic logic tick_of(input int k);
        return (k == 3) ? tick3 : 1'b1;
    endfunction

    // Observed vector: {tx, busy, tx_done, tx_ready}
    function automatic logic [3:0] obs(input int k);
        return {txo[k], bsy[k], dn[k], rdy[k]};
    endfunction

    task automatic chk(input string tag, input int k, input logic [3:0] got, input logic [3:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s u%0d t=%0t {tx,busy,done,ready} got %b want %b", tag, k, $time, got, want);
        end
    endtask

    task automatic gap(input int k);
        @(negedge clk);
        chk("idle_after", k, obs(k), 4'b1001);
    endtask

    // Send word d on instance k starting at a negedge where it is idle.
    // The line must show frame[ticks_elapsed / OVERSAMPLE]; done when the list runs out.
    // hold keeps tx_valid high through the frame; abort_bit >= 0 resets mid-bit.
    task automatic run_frame(input int k, input logic [7:0] d, input bit hold, input int abort_bit);
        logic q[$];
        int os, len, ticks, bi;
        logic [3:0] want;
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par_of(k) == 1) q.push_back(^d);
        if (par_of(k) == 2) q.push_back(~^d);
        for (int i = 0; i < stop_of(k); i++) q.push_back(1'b1);
        os  = os_of(k);
        len = q.size();
        chk("accept_ready", k, {2'b00, bsy[k], rdy[k]}, 4'b0001);
        valid[k] = 1'b1;
        data[k]  = d;
        ticks = 0;
        for (int c = 1; c <= len * os * 3 + 4; c++) begin
            @(negedge clk);
            bi = ticks / os;
            want = (bi < len) ? {q[bi], 1'b1, 1'b0, 1'b0} : 4'b1011;
            chk("frame", k, obs(k), want);
            if (bi >= len) break;
            if (abort_bit >= 0 && bi == abort_bit && (ticks % os) == os / 2) begin
                #2 rst_n = 1'b0;
                #1 chk("reset_midframe", k, obs(k), 4'b1001);
                valid[k] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("reset_hold", k, obs(k), 4'b1001);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("reset_release", k, obs(k), 4'b1001);
                return;
            end
            if (!hold) valid[k] = 1'b0;
            data[k] = 8'($urandom);
            if (tick_of(k)) ticks++;
        end
        if (!hold) valid[k] = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            valid[k] = 1'b0;
            data[k]  = 8'h00;
        end
        #3 rst_n = 1'b0;
        #1 for (int k = 0; k < 4; k++) chk("reset_async", k, obs(k), 4'b1001);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Quiet line with tx_valid low.
        repeat (100) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) chk("idle", k, obs(k), 4'b1001);
        end

        // 8N1 frames.
        run_frame(0, 8'h55, 1'b0, -1); gap(0);
        repeat (3) begin
            run_frame(0, 8'($urandom), 1'b0, -1); gap(0);
        end

        // Even and odd parity.
        run_frame(1, 8'h07, 1'b0, -1); gap(1);
        run_frame(1, 8'($urandom), 1'b0, -1); gap(1);
        run_frame(2, 8'h00, 1'b0, -1); gap(2);
        run_frame(2, 8'h01, 1'b0, -1); gap(2);
        run_frame(2, 8'($urandom), 1'b0, -1); gap(2);

        // Back-to-back with tx_valid held and tx_data scrambled mid-frame.
        run_frame(0, 8'hA3, 1'b1, -1);
        run_frame(0, 8'h3C, 1'b0, -1); gap(0);
        run_frame(2, 8'($urandom), 1'b1, -1);
        run_frame(2, 8'($urandom), 1'b0, -1); gap(2);

        // Two stop bits, slow tick.
        run_frame(3, 8'($urandom), 1'b0, -1); gap(3);
        run_frame(3, 8'($urandom), 1'b1, -1);
        run_frame(3, 8'($urandom), 1'b0, -1); gap(3);

        // Reset during data bit 3 (bit forced low so the line visibly rises).
        d = 8'($urandom) & 8'hF7;
        run_frame(0, d, 1'b0, 4);
        run_frame(0, 8'h96, 1'b0, -1); gap(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
